// File: rtl/sync_edge_filter_pkg.sv
// Shared types and defaults for the synchronizer edge-filter slice.
package sys_structs;

  typedef struct packed {
    logic rise;
    logic fall;
  } edge_evt_s;

  localparam int unsigned DEFAULT_FILTER_DEPTH = 3;

  function automatic edge_evt_s make_evt(input logic old_level);
    edge_evt_s evt;
    evt.rise = ~old_level;
    evt.fall = old_level;
    return evt;
  endfunction

endpackage

// File: rtl/sync_edge_filter_bit.sv
// One-bit deglitch filter: mismatch run counter, accepted level and edge pulse registers.
module sync_edge_filter_bit
  import sys_structs::*;
#(
  parameter int unsigned FILTER_DEPTH = DEFAULT_FILTER_DEPTH,
  parameter logic        RESET_LEVEL  = 1'b0
) (
  input  logic      clk,
  input  logic      async_rst_n,
  input  logic      clk_en,
  input  logic      sync_i,
  output logic      level_o,
  output edge_evt_s evt_o,
  output edge_evt_s evt_d_o
);

  localparam int unsigned COUNT_WIDTH = $clog2(FILTER_DEPTH + 1);
  localparam logic [COUNT_WIDTH-1:0] LAST_CNT = COUNT_WIDTH'(FILTER_DEPTH - 1);

  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   level_q, level_d;
  edge_evt_s              evt_q, evt_d;

  // Disabled cycles hold count and level but still drop any pending pulse.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    evt_d   = '0;
    if (clk_en) begin
      if (sync_i == level_q) begin
        cnt_d = '0;
      end else if (cnt_q == LAST_CNT) begin
        level_d = ~level_q;
        cnt_d   = '0;
        evt_d   = make_evt(level_q);
      end else begin
        cnt_d = cnt_q + COUNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      cnt_q   <= '0;
      level_q <= RESET_LEVEL;
      evt_q   <= '0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      evt_q   <= evt_d;
    end
  end

  assign level_o = level_q;
  assign evt_o   = evt_q;
  assign evt_d_o = evt_d;

endmodule

// File: rtl/sync_edge_filter.sv
// Per-bit stability filter with registered rise/fall strobes and an aggregate change flag.
module sync_edge_filter
  import sys_structs::*;
#(
  parameter int unsigned                 CHAIN_WIDTH  = 4,
  parameter int unsigned                 FILTER_DEPTH = DEFAULT_FILTER_DEPTH,
  parameter logic [CHAIN_WIDTH-1:0]      RESET_LEVEL  = '0
) (
  input  logic                   clk,
  input  logic                   async_rst_n,
  input  logic                   clk_en,
  input  logic [CHAIN_WIDTH-1:0] sync_data_i,
  output logic [CHAIN_WIDTH-1:0] filtered_o,
  output logic [CHAIN_WIDTH-1:0] rise_o,
  output logic [CHAIN_WIDTH-1:0] fall_o,
  output logic                   change_o
);

  logic [CHAIN_WIDTH-1:0] rise_d, fall_d;
  logic                   change_q, change_d;

  for (genvar g = 0; g < CHAIN_WIDTH; g++) begin : g_bit
    edge_evt_s evt_q, evt_d;

    sync_edge_filter_bit #(
      .FILTER_DEPTH (FILTER_DEPTH),
      .RESET_LEVEL  (RESET_LEVEL[g])
    ) u_bit (
      .clk         (clk),
      .async_rst_n (async_rst_n),
      .clk_en      (clk_en),
      .sync_i      (sync_data_i[g]),
      .level_o     (filtered_o[g]),
      .evt_o       (evt_q),
      .evt_d_o     (evt_d)
    );

    assign rise_o[g] = evt_q.rise;
    assign fall_o[g] = evt_q.fall;
    assign rise_d[g] = evt_d.rise;
    assign fall_d[g] = evt_d.fall;
  end

  // Built from the per-bit next-state pulses so it lands in the same cycle as them.
  always_comb begin
    change_d = |(rise_d | fall_d);
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      change_q <= 1'b0;
    end else begin
      change_q <= change_d;
    end
  end

  assign change_o = change_q;

endmodule

// File: tb/tb_sync_edge_filter.sv
// Randomized and directed bench for sync_edge_filter against a sample-history reference model.
module tb_sync_edge_filter;

  localparam int unsigned W     = 4;
  localparam int unsigned DEPTH = 3;

  logic         clk = 1'b0;
  logic         async_rst_n = 1'b0;
  logic         clk_en = 1'b0;
  logic [W-1:0] sync_data_i = '0;
  logic [W-1:0] filtered_o, rise_o, fall_o;
  logic         change_o;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference: each bit keeps its last DEPTH enabled samples; a new level is
  // accepted when all DEPTH most recent enabled samples disagree with it.
  bit           hist [W][$];
  logic [W-1:0] m_lvl, m_rise, m_fall;
  logic         m_change;

  sync_edge_filter #(
    .CHAIN_WIDTH  (W),
    .FILTER_DEPTH (DEPTH),
    .RESET_LEVEL  (4'b0000)
  ) dut (
    .clk         (clk),
    .async_rst_n (async_rst_n),
    .clk_en      (clk_en),
    .sync_data_i (sync_data_i),
    .filtered_o  (filtered_o),
    .rise_o      (rise_o),
    .fall_o      (fall_o),
    .change_o    (change_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_lvl = '0; m_rise = '0; m_fall = '0; m_change = 1'b0;
    for (int b = 0; b < W; b++) hist[b].delete();
  endtask

  task automatic model_edge(input logic [W-1:0] d, input logic en);
    bit all_diff;
    m_rise = '0; m_fall = '0;
    if (en) begin
      for (int b = 0; b < W; b++) begin
        hist[b].push_back(d[b]);
        if (hist[b].size() > DEPTH) void'(hist[b].pop_front());
        if (hist[b].size() == DEPTH) begin
          all_diff = 1'b1;
          foreach (hist[b][k]) if (hist[b][k] == m_lvl[b]) all_diff = 1'b0;
          if (all_diff) begin
            if (m_lvl[b]) m_fall[b] = 1'b1; else m_rise[b] = 1'b1;
            m_lvl[b] = ~m_lvl[b];
            hist[b].delete();
          end
        end
      end
    end
    m_change = |(m_rise | m_fall);
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".filt"},   filtered_o, m_lvl);
    check({tag, ".rise"},   rise_o,     m_rise);
    check({tag, ".fall"},   fall_o,     m_fall);
    check({tag, ".change"}, change_o,   m_change);
  endtask

  task automatic step(input logic [W-1:0] d, input logic en, input string tag);
    sync_data_i = d;
    clk_en      = en;
    @(posedge clk);
    #1;
    model_edge(d, en);
    compare_all(tag);
  endtask

  // Assert reset between edges, check the outputs clear before any clock edge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2 async_rst_n = 1'b0;
    #1;
    model_reset();
    compare_all(tag);
    @(posedge clk);
    @(negedge clk);
    async_rst_n = 1'b1;
  endtask

  initial begin
    logic [W-1:0] rd;
    logic         ren;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    async_rst_n = 1'b1;

    // Build some nonzero state, then check asynchronous clear.
    repeat (4) step(4'b1010, 1'b1, "pre");
    check("pre.level", filtered_o, 4'b1010);
    do_reset("rst_async");

    // Single-bit acceptance and one-cycle rise strobe.
    step(4'b0001, 1'b1, "t2a");
    step(4'b0001, 1'b1, "t2b");
    check("t2.hold", filtered_o, 4'b0000);
    step(4'b0001, 1'b1, "t2c");
    check("t2.accept", filtered_o, 4'b0001);
    check("t2.rise", rise_o, 4'b0001);
    step(4'b0001, 1'b1, "t2d");
    check("t2.rise_gone", rise_o, 4'b0000);
    step(4'b0001, 1'b1, "t2e");

    // Two-cycle glitch on bit1 is rejected.
    step(4'b0011, 1'b1, "t3a");
    step(4'b0011, 1'b1, "t3b");
    step(4'b0001, 1'b1, "t3c");
    step(4'b0011, 1'b1, "t3d");
    step(4'b0011, 1'b1, "t3e");
    check("t3.glitch", filtered_o, 4'b0001);
    check("t3.nopulse", rise_o | fall_o, 4'b0000);
    step(4'b0001, 1'b1, "t3f");

    // Enable gaps hold the count without clearing it.
    do_reset("rst_t4");
    step(4'b0001, 1'b1, "t4a");
    step(4'b0001, 1'b1, "t4b");
    step(4'b0001, 1'b0, "t4c");
    check("t4.gap_rise", rise_o, 4'b0000);
    step(4'b0001, 1'b0, "t4d");
    check("t4.gap_level", filtered_o, 4'b0000);
    step(4'b0001, 1'b1, "t4e");
    check("t4.accept", filtered_o, 4'b0001);
    check("t4.rise", rise_o, 4'b0001);

    // Simultaneous rise and fall on different bits.
    do_reset("rst_t5");
    repeat (3) step(4'b1000, 1'b1, "t5a");
    check("t5.base", filtered_o, 4'b1000);
    repeat (3) step(4'b0100, 1'b1, "t5b");
    check("t5.level", filtered_o, 4'b0100);
    check("t5.rise", rise_o, 4'b0100);
    check("t5.fall", fall_o, 4'b1000);
    check("t5.change", change_o, 1'b1);

    // Reset mid-count discards progress.
    do_reset("rst_t6a");
    step(4'b0010, 1'b1, "t6a");
    step(4'b0010, 1'b1, "t6b");
    do_reset("rst_t6b");
    step(4'b0010, 1'b1, "t6c");
    step(4'b0010, 1'b1, "t6d");
    check("t6.not_yet", filtered_o, 4'b0000);
    step(4'b0010, 1'b1, "t6e");
    check("t6.accept", filtered_o, 4'b0010);

    // Random run: slowly varying bits with occasional glitches and enable gaps.
    rd = '0;
    for (int i = 0; i < 600; i++) begin
      for (int b = 0; b < W; b++) if ($urandom_range(0, 5) == 0) rd[b] = ~rd[b];
      ren = ($urandom_range(0, 6) != 0);
      if ($urandom_range(0, 150) == 0) do_reset("rnd_rst");
      step(rd, ren, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

endmodule
